// File: rtl/nibble_serializer.sv
// rtl/nibble_serializer.sv - word-to-nibble feeder with credit tracking for a 4-bit queue
// Optional macro NIBBLE_SER_DEQ_YIELD_EN: yield enq to any coincident consumer dequeue.
module nibble_serializer #(
   parameter int WORD_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              deq_in,
   output logic              enq,
   output logic [3:0]        din,
   output logic              busy,
   output logic [2:0]        occ
);

   localparam int NIBBLES = WORD_W / 4;
   localparam int CNT_W   = $clog2(NIBBLES + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] shreg_next;
   logic [CNT_W-1:0]  cnt;
   logic              room;

   assign shreg_next = shreg >> 4;
   assign room       = (occ < 3'(DEPTH));

`ifdef NIBBLE_SER_DEQ_YIELD_EN
   assign enq = (state == SHIFT) && room && !deq_in;
`else
   assign enq = (state == SHIFT) && room;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         shreg    <= '0;
         cnt      <= '0;
         occ      <= '0;
         din      <= '0;
         in_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         // The queue services enq ahead of deq, so a dequeue coincident with enq is dropped.
         if (enq)
            occ <= occ + 3'd1;
         else if (deq_in && (occ != 3'd0))
            occ <= occ - 3'd1;

         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  shreg    <= in_data;
                  din      <= in_data[3:0];
                  cnt      <= CNT_W'(NIBBLES);
                  state    <= SHIFT;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SHIFT: begin
               if (enq) begin
                  shreg <= shreg_next;
                  cnt   <= cnt - CNT_W'(1);
                  // din keeps the last nibble once the word is done.
                  if (cnt == CNT_W'(1)) begin
                     state    <= IDLE;
                     in_ready <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     din <= shreg_next[3:0];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serializer.sv
// tb/tb_nibble_serializer.sv - scoreboard bench for nibble_serializer
module tb_nibble_serializer;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        deq_in = 1'b0;
   logic        enq;
   logic [3:0]  din;
   logic        busy;
   logic [2:0]  occ;

   int errors = 0;
   int checks = 0;
   int n_enq  = 0;
   logic [3:0] exp_q[$];

   nibble_serializer #(.WORD_W(16), .DEPTH(4)) dut (
      .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .deq_in(deq_in), .enq(enq), .din(din),
      .busy(busy), .occ(occ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every enq must carry the next expected nibble.
   always @(negedge clk) begin
      if (nrst && enq) begin
         n_enq++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_enq: got din=%0h expected no enq", din);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (din !== e) begin
               errors++;
               $display("FAIL din: got %0h expected %0h", din, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int i;
      for (i = 0; i < 40 && !in_ready; i++) step();
      chk({name, "_ready"}, in_ready, 1'b1);
   endtask

   // Issue a word; n nibbles are expected to reach the queue.
   task automatic send(input logic [15:0] w, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(w[k*4 +: 4]);
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      deq_in = 1'b1;
      for (int i = 0; i < 10 && occ != 3'd0; i++) step();
      deq_in = 1'b0;
      chk("drain_occ", occ, 3'd0);
   endtask

   int base;

   initial begin
      #12;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_enq", enq, 1'b0);
      chk("rst_din", din, 4'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_occ", occ, 3'd0);
      nrst = 1'b1;
      step();

      // Basic word, free queue: 3,C,5,A back to back.
      base = n_enq;
      send(16'hA5C3, 4);
      chk("w1_busy", busy, 1'b1);
      wait_ready("w1");
      chk("w1_enq_count", n_enq - base, 4);
      chk("w1_occ", occ, 3'd4);
      chk("w1_din_hold", din, 4'hA);

      // Queue full: word stalls until credits return.
      send(16'h1234, 4);
      chk("full_enq", enq, 1'b0);
      chk("full_busy", busy, 1'b1);
      chk("full_in_ready", in_ready, 1'b0);
      step();
      chk("full_enq2", enq, 1'b0);
      deq_in = 1'b1;
      step();
      deq_in = 1'b0;
      chk("refill_occ3", occ, 3'd3);
      chk("refill_enq", enq, 1'b1);
      chk("refill_din", din, 4'h4);
      step();
      chk("refill_occ4", occ, 3'd4);
      chk("refill_stall", enq, 1'b0);
      for (int k = 0; k < 3; k++) begin
         deq_in = 1'b1;
         step();
         deq_in = 1'b0;
         step();
      end
      wait_ready("w2");
      chk("w2_occ", occ, 3'd4);

      // Drain, then dequeues on an empty queue must not underflow.
      drain();
      deq_in = 1'b1;
      step();
      step();
      deq_in = 1'b0;
      chk("underflow_occ", occ, 3'd0);

      // Dequeue coincident with an enq at occ=2.
      send(16'h7654, 4);
      step();
      step();
      chk("coinc_occ2", occ, 3'd2);
      deq_in = 1'b1;
`ifdef NIBBLE_SER_DEQ_YIELD_EN
      chk("coinc_enq", enq, 1'b0);
`else
      chk("coinc_enq", enq, 1'b1);
`endif
      step();
      deq_in = 1'b0;
`ifdef NIBBLE_SER_DEQ_YIELD_EN
      chk("coinc_occ_after", occ, 3'd1);
      chk("coinc_enq_next", enq, 1'b1);
      chk("coinc_din_next", din, 4'h6);
      wait_ready("w3");
      chk("w3_occ", occ, 3'd3);
`else
      chk("coinc_occ_after", occ, 3'd3);
      wait_ready("w3");
      chk("w3_occ", occ, 3'd4);
`endif
      drain();

      // Reset mid-word after two nibbles of 0xBEEF.
      send(16'hBEEF, 2);
      @(posedge clk);
      @(posedge clk);
      #1;
      nrst = 1'b0;
      #1;
      chk("midrst_enq", enq, 1'b0);
      chk("midrst_occ", occ, 3'd0);
      chk("midrst_busy", busy, 1'b0);
      step();
      nrst = 1'b1;
      chk("postrst_ready", in_ready, 1'b1);
      base = n_enq;
      send(16'h0F0F, 4);
      wait_ready("w4");
      chk("w4_enq_count", n_enq - base, 4);
      chk("w4_occ", occ, 3'd4);
      step();
      chk("sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
